// File: rtl/polyveck_power2round_stream.sv
// Streaming Power2Round over a K x N coefficient vector, LANES coefficients per beat.
// One register stage: each accepted beat appears split into (a1, a0) on the next cycle.
module polyveck_power2round_stream #(
   parameter int K     = 6,
   parameter int N     = 256,
   parameter int LANES = 8,
   parameter int D     = 13,
   parameter int Q     = 8380417,
   parameter int CW    = 32,
   parameter int CADDQ = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LANES*CW-1:0]                in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [LANES*CW-1:0]                out_a1,
   output logic [LANES*CW-1:0]                out_a0,
   output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_poly_idx,
   output logic                               out_last_poly,
   output logic                               out_last_vec,
   output logic                               range_err,
   input  logic                               clear_err
);

   localparam int BEATS = N / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = (K > 1) ? $clog2(K) : 1;

   localparam logic signed [CW:0] Q_EXT = (CW+1)'(Q);
   localparam logic signed [CW:0] RND   = (CW+1)'((1 << (D - 1)) - 1);

   if (K < 1 || LANES < 1 || (N % LANES) != 0 || CW < D + 2) begin : g_bad_params
      $error("polyveck_power2round_stream: illegal parameter set");
   end

   logic                  accept;
   logic [BW-1:0]         beat_cnt;
   logic [PW-1:0]         poly_cnt;
   logic                  beat_last;
   logic                  poly_last;
   logic [LANES*CW-1:0]   a1_next;
   logic [LANES*CW-1:0]   a0_next;
   logic [LANES-1:0]      lane_bad;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign beat_last = (beat_cnt == BW'(BEATS - 1));
   assign poly_last = (poly_cnt == PW'(K - 1));

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [CW-1:0] a;
      logic signed [CW:0]   a_ext;
      logic signed [CW:0]   r;
      logic signed [CW:0]   sum;
      logic signed [CW-1:0] a1;
      logic signed [CW:0]   a1_ext;

      assign a     = in_data[CW*i +: CW];
      assign a_ext = {a[CW-1], a};

      if (CADDQ != 0) begin : g_caddq
         assign r           = a[CW-1] ? a_ext + Q_EXT : a_ext;
         assign lane_bad[i] = (a_ext < -Q_EXT) || (a_ext >= Q_EXT);
      end else begin : g_plain
         assign r           = a_ext;
         assign lane_bad[i] = a[CW-1] || (a_ext >= Q_EXT);
      end

      // After an arithmetic shift by D>=1 the top two bits agree, so the CW-bit
      // a1 sign-extended back to CW+1 bits equals the full-width quotient.
      assign sum    = r + RND;
      assign a1     = CW'(sum >>> D);
      assign a1_ext = {a1[CW-1], a1};

      assign a1_next[CW*i +: CW] = a1;
      assign a0_next[CW*i +: CW] = CW'(r - (a1_ext <<< D));
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_a1        <= '0;
         out_a0        <= '0;
         out_poly_idx  <= '0;
         out_last_poly <= 1'b0;
         out_last_vec  <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_a1        <= a1_next;
         out_a0        <= a0_next;
         out_poly_idx  <= poly_cnt;
         out_last_poly <= beat_last;
         out_last_vec  <= beat_last && poly_last;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Position advances only on acceptance; the vector wraps with no idle beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         poly_cnt <= '0;
      end else if (accept) begin
         if (beat_last) begin
            beat_cnt <= '0;
            poly_cnt <= poly_last ? '0 : poly_cnt + 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // A fresh error outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         range_err <= 1'b0;
      end else if (accept && (|lane_bad)) begin
         range_err <= 1'b1;
      end else if (clear_err) begin
         range_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_polyveck_power2round_stream.sv
// Directed bench for polyveck_power2round_stream: split values, range flag,
// position flags, stalls against a scoreboard, mid-vector reset, vector wrap.
module tb_polyveck_power2round_stream;

   localparam int K     = 6;
   localparam int N     = 256;
   localparam int LANES = 8;
   localparam int D     = 13;
   localparam int Q     = 8380417;
   localparam int CW    = 32;
   localparam int BEATS = N / LANES;
   localparam int VBEATS = BEATS * K;

   typedef logic [LANES*CW-1:0] vec_t;

   typedef struct {
      vec_t       a1;
      vec_t       a0;
      logic [2:0] poly;
      logic       lp;
      logic       lv;
   } beat_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   vec_t       in_data;
   logic       out_valid;
   logic       out_ready;
   vec_t       out_a1;
   vec_t       out_a0;
   logic [2:0] out_poly_idx;
   logic       out_last_poly;
   logic       out_last_vec;
   logic       range_err;
   logic       clear_err;

   int checks;
   int errors;

   polyveck_power2round_stream #(
      .K(K), .N(N), .LANES(LANES), .D(D), .Q(Q), .CW(CW), .CADDQ(1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_a1       (out_a1),
      .out_a0       (out_a0),
      .out_poly_idx (out_poly_idx),
      .out_last_poly(out_last_poly),
      .out_last_vec (out_last_vec),
      .range_err    (range_err),
      .clear_err    (clear_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t rep(input int v);
      vec_t x;
      for (int i = 0; i < LANES; i++) x[CW*i +: CW] = v;
      return x;
   endfunction

   // Reference split via integer division on the caddq-corrected value.
   function automatic void p2r(input int a, output int a1, output int a0);
      int r;
      r  = (a < 0) ? a + Q : a;
      a1 = (r + (1 << (D - 1)) - 1) / (1 << D);
      a0 = r - a1 * (1 << D);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      clear_err = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_one(input vec_t d);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      send_one(rep(4097));
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_a1 !== '0) begin errors++; $display("FAIL reset_a1: got %h expected 0", out_a1); end
      checks++; if (out_a0 !== '0) begin errors++; $display("FAIL reset_a0: got %h expected 0", out_a0); end
      checks++; if (out_poly_idx !== 3'd0) begin errors++; $display("FAIL reset_poly: got %0d expected 0", out_poly_idx); end
      checks++; if (out_last_poly !== 1'b0 || out_last_vec !== 1'b0) begin errors++; $display("FAIL reset_last: got %b%b expected 00", out_last_poly, out_last_vec); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", range_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_split();
      int vin [4] = '{0, 4096, 4097, 8380416};
      int e1  [4] = '{0, 0, 1, 1023};
      int e0  [4] = '{0, 4096, -4095, 0};
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rep(vin[0]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL split_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_a1 !== rep(e1[i])) begin errors++; $display("FAIL split_a1[%0d]: got %h expected %h", i, out_a1, rep(e1[i])); end
         checks++; if (out_a0 !== rep(e0[i])) begin errors++; $display("FAIL split_a0[%0d]: got %h expected %h", i, out_a0, rep(e0[i])); end
         if (i < 3) in_data = rep(vin[i+1]);
         else in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL split_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_caddq_range();
      vec_t d;
      do_reset();
      send_one(rep(-1));
      checks++; if (out_a1 !== rep(1023) || out_a0 !== rep(0)) begin errors++; $display("FAIL caddq_m1: got %h/%h expected 1023/0", out_a1, out_a0); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL caddq_m1_err: got %b expected 0", range_err); end
      send_one(rep(-8380417));
      checks++; if (out_a1 !== rep(0) || out_a0 !== rep(0)) begin errors++; $display("FAIL caddq_mq: got %h/%h expected 0/0", out_a1, out_a0); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL edge_mq_err: got %b expected 0", range_err); end
      send_one(rep(8380417));
      checks++; if (out_a1 !== rep(1023) || out_a0 !== rep(1)) begin errors++; $display("FAIL q_split: got %h/%h expected 1023/1", out_a1, out_a0); end
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL edge_q_err: got %b expected 1", range_err); end
      pulse_clear();
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL clear1: got %b expected 0", range_err); end
      send_one(rep(-8380418));
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL low_err: got %b expected 1", range_err); end
      checks++; if (out_a1 !== rep(0) || out_a0 !== rep(-1)) begin errors++; $display("FAIL low_split: got %h/%h expected 0/-1", out_a1, out_a0); end
      repeat (3) @(negedge clk);
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", range_err); end
      pulse_clear();
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL clear2: got %b expected 0", range_err); end
      d = rep(5);
      d[CW*5 +: CW] = -9000000;
      send_one(d);
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL one_lane_err: got %b expected 1", range_err); end
      pulse_clear();
      @(negedge clk);
      in_data   = rep(-8380418);
      in_valid  = 1'b1;
      clear_err = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      clear_err = 1'b0;
      checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", range_err); end
   endtask

   // Continuous stream with out_ready high; beat j carries value j in every lane.
   task automatic run_stream(input int n, input string tag);
      logic [2:0] ep;
      logic       elp, elv;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = rep(0);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         ep  = 3'((j / BEATS) % K);
         elp = ((j % BEATS) == BEATS - 1);
         elv = ((j % VBEATS) == VBEATS - 1);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d]: got %b expected 1", tag, j, out_valid); end
         checks++; if (out_poly_idx !== ep) begin errors++; $display("FAIL %s_poly[%0d]: got %0d expected %0d", tag, j, out_poly_idx, ep); end
         checks++; if (out_last_poly !== elp) begin errors++; $display("FAIL %s_lastpoly[%0d]: got %b expected %b", tag, j, out_last_poly, elp); end
         checks++; if (out_last_vec !== elv) begin errors++; $display("FAIL %s_lastvec[%0d]: got %b expected %b", tag, j, out_last_vec, elv); end
         checks++; if (out_a0 !== rep(j)) begin errors++; $display("FAIL %s_a0[%0d]: got %h expected %h", tag, j, out_a0, rep(j)); end
         if (j + 1 < n) in_data = rep(j + 1);
         else in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b expected 0", tag, out_valid); end
   endtask

   task automatic test_vector_flags();
      do_reset();
      run_stream(VBEATS, "vec");
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_stream(2 * VBEATS, "b2b");
   endtask

   task automatic test_mid_reset();
      do_reset();
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int j = 0; j < 50; j++) begin
         in_data = rep(j);
         @(negedge clk);
      end
      checks++; if (out_poly_idx !== 3'd1) begin errors++; $display("FAIL mid_pre_poly: got %0d expected 1", out_poly_idx); end
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      checks++; if (out_poly_idx !== 3'd0) begin errors++; $display("FAIL mid_rst_poly: got %0d expected 0", out_poly_idx); end
      run_stream(BEATS, "mid");
   endtask

   task automatic test_stall_random();
      beat_t q[$];
      beat_t b;
      int    acc_cnt;
      int    rx_cnt;
      int    v, a1, a0;
      logic  exp_rdy;
      acc_cnt = 0;
      rx_cnt  = 0;
      do_reset();
      @(negedge clk);
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected %b", cyc, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            checks++; if (out_a1 !== q[0].a1 || out_a0 !== q[0].a0) begin errors++; $display("FAIL stall_data[%0d]: got %h/%h expected %h/%h", cyc, out_a1, out_a0, q[0].a1, q[0].a0); end
            checks++; if (out_poly_idx !== q[0].poly || out_last_poly !== q[0].lp || out_last_vec !== q[0].lv) begin errors++; $display("FAIL stall_pos[%0d]: got %0d%b%b expected %0d%b%b", cyc, out_poly_idx, out_last_poly, out_last_vec, q[0].poly, q[0].lp, q[0].lv); end
         end
         in_valid  = (cyc < 380) && ($urandom_range(0, 3) != 0);
         out_ready = (cyc >= 380) || ($urandom_range(0, 2) != 0);
         for (int i = 0; i < LANES; i++) begin
            v = int'($urandom_range(0, 2 * Q - 1)) - Q;
            in_data[CW*i +: CW] = v;
            p2r(v, a1, a0);
            b.a1[CW*i +: CW] = a1;
            b.a0[CW*i +: CW] = a0;
         end
         b.poly = 3'((acc_cnt / BEATS) % K);
         b.lp   = ((acc_cnt % BEATS) == BEATS - 1);
         b.lv   = ((acc_cnt % VBEATS) == VBEATS - 1);
         exp_rdy = (q.size() == 0) || out_ready;
         #1;
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected %b", cyc, in_ready, exp_rdy); end
         if (q.size() != 0 && out_ready) begin
            void'(q.pop_front());
            rx_cnt++;
         end
         if (in_valid && exp_rdy) begin
            q.push_back(b);
            acc_cnt++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (q.size() != 0 || rx_cnt != acc_cnt) begin errors++; $display("FAIL stall_count: got %0d received expected %0d", rx_cnt, acc_cnt); end
      checks++; if (acc_cnt < 100) begin errors++; $display("FAIL stall_traffic: got %0d accepted expected at least 100", acc_cnt); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      clear_err = 1'b0;
      test_reset();
      test_split();
      test_caddq_range();
      test_vector_flags();
      test_stall_random();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
